prv_trap_ctrl: RTL

- Priv-block responder to the pipeline's hazard-side trap requests; the other end of the priv/pipeline trap handshake.
- Prioritises synchronous exceptions, machine interrupts and mret.
- Updates mepc/mcause/mtval and mstatus.MIE/MPIE.
- Drives a one-cycle insert_pc pulse with the redirect target priv_pc; intr tells the hazard unit an enabled interrupt is pending.

---
 rtl/prv_trap_pkg.sv | 35 +++
 rtl/prv_trap_if.sv | 43 ++++
 rtl/prv_trap_prio.sv | 56 +++++
 rtl/prv_trap_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/prv_trap_pkg.sv
// Shared types for the machine-mode trap controller.
// Holds the cause codes, FSM states, mtvec mode encoding and a width helper.
package prv_trap_pkg;

    typedef enum logic [4:0] {
        EXC_MAL_INSN   = 5'd0,
        EXC_FAULT_INSN = 5'd1,
        EXC_ILLEGAL    = 5'd2,
        EXC_BREAK      = 5'd3,
        EXC_MAL_L      = 5'd4,
        EXC_FAULT_L    = 5'd5,
        EXC_MAL_S      = 5'd6,
        EXC_FAULT_S    = 5'd7,
        EXC_ENV_M      = 5'd11
    } exc_cause_e;

    typedef enum logic [4:0] {
        IRQ_MSI = 5'd3,
        IRQ_MTI = 5'd7,
        IRQ_MEI = 5'd11
    } irq_cause_e;

    typedef enum logic {
        IDLE   = 1'b0,
        INSERT = 1'b1
    } trap_state_t;

    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // A single extension still needs a 1-bit index port.
    function automatic int cause_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prv_trap_if.sv
// Pipeline <-> priv trap handshake: requests from the hazard side,
// redirect strobe/target and interrupt-pending flag back to it.
interface prv_trap_if
    import prv_trap_pkg::*;
#(
    parameter int NUM_EXTENSIONS = 2
);
    localparam int CW = cause_w(NUM_EXTENSIONS);

    logic          pipe_clear;
    logic          ret;
    logic          mal_insn;
    logic          fault_insn;
    logic          illegal_insn;
    logic          breakpoint;
    logic          env_m;
    logic          mal_l;
    logic          mal_s;
    logic          fault_l;
    logic          fault_s;
    logic          ex_rmgmt;
    logic [CW-1:0] ex_rmgmt_cause;
    logic [31:0]   epc;
    logic [31:0]   badaddr;
    logic          insert_pc;
    logic [31:0]   priv_pc;
    logic          intr;

    modport master (
        output pipe_clear, ret, mal_insn, fault_insn, illegal_insn,
               breakpoint, env_m, mal_l, mal_s, fault_l, fault_s,
               ex_rmgmt, ex_rmgmt_cause, epc, badaddr,
        input  insert_pc, priv_pc, intr
    );

    modport slave (
        input  pipe_clear, ret, mal_insn, fault_insn, illegal_insn,
               breakpoint, env_m, mal_l, mal_s, fault_l, fault_s,
               ex_rmgmt, ex_rmgmt_cause, epc, badaddr,
        output insert_pc, priv_pc, intr
    );

endinterface

// File: rtl/prv_trap_prio.sv
// Combinational trap priority encoder: exceptions first, then enabled
// interrupts MEI > MSI > MTI. Outputs valid, is_intr and the 5-bit code.
module prv_trap_prio
    import prv_trap_pkg::*;
#(
    parameter int NUM_EXTENSIONS   = 2,
    parameter int RMGMT_CAUSE_BASE = 24,
    localparam int CW = cause_w(NUM_EXTENSIONS)
) (
    input  logic          mal_insn,
    input  logic          fault_insn,
    input  logic          illegal_insn,
    input  logic          breakpoint,
    input  logic          env_m,
    input  logic          mal_l,
    input  logic          mal_s,
    input  logic          fault_l,
    input  logic          fault_s,
    input  logic          ex_rmgmt,
    input  logic [CW-1:0] rmgmt_cause,
    input  logic [2:0]    irq_vec,
    output logic          valid,
    output logic          is_intr,
    output logic [4:0]    code
);

    always_comb begin
        valid   = 1'b1;
        is_intr = 1'b0;
        code    = EXC_MAL_INSN;
        if (mal_insn)          code = EXC_MAL_INSN;
        else if (fault_insn)   code = EXC_FAULT_INSN;
        else if (illegal_insn) code = EXC_ILLEGAL;
        else if (breakpoint)   code = EXC_BREAK;
        else if (env_m)        code = EXC_ENV_M;
        else if (mal_l)        code = EXC_MAL_L;
        else if (mal_s)        code = EXC_MAL_S;
        else if (fault_l)      code = EXC_FAULT_L;
        else if (fault_s)      code = EXC_FAULT_S;
        else if (ex_rmgmt)
            code = 5'(RMGMT_CAUSE_BASE) + 5'(rmgmt_cause);
        else if (irq_vec[2]) begin
            is_intr = 1'b1;
            code    = IRQ_MEI;
        end else if (irq_vec[0]) begin
            is_intr = 1'b1;
            code    = IRQ_MSI;
        end else if (irq_vec[1]) begin
            is_intr = 1'b1;
            code    = IRQ_MTI;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/prv_trap_ctrl.sv
// Machine trap controller: takes exceptions, interrupts and mret, updates
// mepc/mcause/mtval/mstatus and pulses insert_pc with the redirect target.
module prv_trap_ctrl
    import prv_trap_pkg::*;
#(
    parameter int NUM_EXTENSIONS   = 2,
    parameter int RMGMT_CAUSE_BASE = 24
) (
    input  logic        CLK,
    input  logic        RST,
    prv_trap_if.slave   bus,
    input  logic [31:0] mtvec,
    input  logic [2:0]  irq_pend,
    input  logic [2:0]  irq_en,
    input  logic        csr_mie_we,
    input  logic        csr_mie_wdata,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        mstatus_mie,
    output logic        mstatus_mpie
);

    trap_state_t state_q, state_d;
    logic        insert_pc_q, insert_pc_d;
    logic [31:0] priv_pc_q, priv_pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;

    logic [2:0]  irq_vec;
    logic        p_valid;
    logic        p_intr;
    logic [4:0]  p_code;
    logic        take_exc;
    logic        take_irq;
    logic        tval_sel;
    logic [31:0] base;

    assign irq_vec = {3{mie_q}} & irq_pend & irq_en;
    assign bus.intr = |irq_vec;

    prv_trap_prio #(
        .NUM_EXTENSIONS   (NUM_EXTENSIONS),
        .RMGMT_CAUSE_BASE (RMGMT_CAUSE_BASE)
    ) u_prio (
        .mal_insn     (bus.mal_insn),
        .fault_insn   (bus.fault_insn),
        .illegal_insn (bus.illegal_insn),
        .breakpoint   (bus.breakpoint),
        .env_m        (bus.env_m),
        .mal_l        (bus.mal_l),
        .mal_s        (bus.mal_s),
        .fault_l      (bus.fault_l),
        .fault_s      (bus.fault_s),
        .ex_rmgmt     (bus.ex_rmgmt),
        .rmgmt_cause  (bus.ex_rmgmt_cause),
        .irq_vec      (irq_vec),
        .valid        (p_valid),
        .is_intr      (p_intr),
        .code         (p_code)
    );

    assign take_exc = p_valid & ~p_intr;
    assign take_irq = p_valid & p_intr & bus.pipe_clear;
    assign base     = {mtvec[31:2], 2'b00};

    // Only address/instruction faults report badaddr; ecall and
    // extension exceptions write zero.
    assign tval_sel = (p_code != EXC_ENV_M) &
                      |{bus.mal_insn, bus.fault_insn, bus.illegal_insn,
                        bus.breakpoint, bus.mal_l, bus.mal_s,
                        bus.fault_l, bus.fault_s};

    always_comb begin
        state_d     = state_q;
        insert_pc_d = 1'b0;
        priv_pc_d   = priv_pc_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mtval_d     = mtval_q;
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        unique case (state_q)
            IDLE: begin
                if (take_exc) begin
                    mepc_d      = bus.epc;
                    mcause_d    = {27'd0, p_code};
                    mtval_d     = tval_sel ? bus.badaddr : 32'd0;
                    mpie_d      = mie_q;
                    mie_d       = 1'b0;
                    priv_pc_d   = base;
                    insert_pc_d = 1'b1;
                    state_d     = INSERT;
                end else if (take_irq) begin
                    mepc_d      = bus.epc;
                    mcause_d    = {1'b1, 26'd0, p_code};
                    mtval_d     = 32'd0;
                    mpie_d      = mie_q;
                    mie_d       = 1'b0;
                    if (mtvec[1:0] == MTVEC_MODE_VECTORED)
                        priv_pc_d = base + {25'd0, p_code, 2'b00};
                    else
                        priv_pc_d = base;
                    insert_pc_d = 1'b1;
                    state_d     = INSERT;
                end else if (bus.ret) begin
                    mie_d       = mpie_q;
                    mpie_d      = 1'b1;
                    priv_pc_d   = mepc_q;
                    insert_pc_d = 1'b1;
                    state_d     = INSERT;
                end else if (csr_mie_we) begin
                    mie_d = csr_mie_wdata;
                end
            end
            INSERT: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            insert_pc_q <= 1'b0;
            priv_pc_q   <= 32'd0;
            mepc_q      <= 32'd0;
            mcause_q    <= 32'd0;
            mtval_q     <= 32'd0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            insert_pc_q <= insert_pc_d;
            priv_pc_q   <= priv_pc_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
        end
    end

    assign bus.insert_pc = insert_pc_q;
    assign bus.priv_pc   = priv_pc_q;
    assign mepc          = mepc_q;
    assign mcause        = mcause_q;
    assign mtval         = mtval_q;
    assign mstatus_mie   = mie_q;
    assign mstatus_mpie  = mpie_q;

endmodule
